// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store unit between the mem stage and a
// request/grant/response bus. One access at a time, IDLE -> REQ -> WAIT -> DONE.
//
// Handshakes:
//   upstream: req_valid is held stable by the pipeline while stall_o=1.
//   bus:      bus_req is held with constant address/be/wdata/we until the cycle
//             bus_gnt=1 is seen (that cycle completes the request).
//             bus_rvalid is only observed in WAIT; it carries load data or a
//             store acknowledge.
module lsu_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic        stall_o,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata,
   output logic        wb_we,
   output logic [4:0]  wb_waddr,
   output logic [31:0] wb_wdata,
   output logic        misalign_o,
   output logic        bus_err_o,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, uns_q;
   logic [1:0]  size_q;
   logic [4:0]  rd_q;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        tmo_q, tmo_d;
   logic        aligned;
   logic        latch_en;
   logic [31:0] load_val;
   logic [7:0]  lane8;
   logic [15:0] lane16;

   assign dbg_state_o = state_q;

   // Alignment check and bus lane formatting of the incoming request.
   always_comb begin
      aligned = 1'b0;
      be_d    = 4'b0000;
      wdata_d = req_wdata;
      unique case (req_size)
         2'b00: begin
            aligned = 1'b1;
            be_d    = 4'b0001 << req_addr[1:0];
            wdata_d = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            aligned = ~req_addr[0];
            be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{req_wdata[15:0]}};
         end
         2'b10: begin
            aligned = (req_addr[1:0] == 2'b00);
            be_d    = 4'b1111;
            wdata_d = req_wdata;
         end
         default: begin
            aligned = 1'b0;
         end
      endcase
   end

   // Next-state logic plus the combinational stall/exception outputs.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tmo_d      = tmo_q;
      rdata_d    = rdata_q;
      latch_en   = 1'b0;
      stall_o    = 1'b0;
      misalign_o = 1'b0;
      bus_err_o  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (aligned) begin
                  stall_o  = 1'b1;
                  latch_en = 1'b1;
                  state_d  = S_REQ;
               end else begin
                  misalign_o = 1'b1;
               end
            end
         end
         S_REQ: begin
            stall_o = 1'b1;
            if (bus_gnt) begin
               state_d = S_WAIT;
               cnt_d   = 8'd0;
               tmo_d   = 1'b0;
            end
         end
         S_WAIT: begin
            stall_o = 1'b1;
            if (bus_rvalid) begin
               rdata_d = bus_rdata;
               state_d = S_DONE;
            end else if (cnt_q == 8'hFF) begin
               // No response after 256 WAIT cycles: abandon with an error pulse.
               bus_err_o = 1'b1;
               tmo_d     = 1'b1;
               state_d   = S_DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, counter, response data and latched request fields.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         tmo_q   <= 1'b0;
         rdata_q <= 32'd0;
         addr_q  <= 32'd0;
         be_q    <= 4'd0;
         wdata_q <= 32'd0;
         we_q    <= 1'b0;
         size_q  <= 2'd0;
         uns_q   <= 1'b0;
         rd_q    <= 5'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         rdata_q <= rdata_d;
         if (latch_en) begin
            addr_q  <= req_addr;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            rd_q    <= req_rd;
         end
      end
   end

   // Bus request fields are driven only while requesting, zero otherwise.
   always_comb begin
      bus_req   = (state_q == S_REQ);
      bus_we    = bus_req & we_q;
      bus_addr  = bus_req ? {addr_q[31:2], 2'b00} : 32'd0;
      bus_be    = bus_req ? be_q : 4'd0;
      bus_wdata = bus_req ? wdata_q : 32'd0;
   end

   // Lane extraction and sign/zero extension of the captured load word.
   always_comb begin
      lane8  = rdata_q[{addr_q[1:0], 3'b000} +: 8];
      lane16 = rdata_q[{addr_q[1], 4'b0000} +: 16];
      unique case (size_q)
         2'b00:   load_val = uns_q ? {24'd0, lane8} : {{24{lane8[7]}}, lane8};
         2'b01:   load_val = uns_q ? {16'd0, lane16} : {{16{lane16[15]}}, lane16};
         default: load_val = rdata_q;
      endcase
   end

   // Writeback only for a completed load to a non-zero register.
   always_comb begin
      wb_we    = (state_q == S_DONE) & ~we_q & ~tmo_q & (rd_q != 5'd0);
      wb_waddr = wb_we ? rd_q : 5'd0;
      wb_wdata = wb_we ? load_val : 32'd0;
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: directed scenarios followed by random accesses,
// checked cycle by cycle against an arithmetic reference of the access rules.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        stall_o, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        misalign_o, bus_err_o;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errs   = 0;

  lsu_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .stall_o(stall_o), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic is_aligned(input logic [1:0] sz, input logic [31:0] a);
    int off;
    off = int'(a[1:0]);
    case (sz)
      2'd0:    return 1'b1;
      2'd1:    return (off % 2) == 0;
      2'd2:    return off == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
    int off;
    off = int'(a[1:0]);
    case (sz)
      2'd0:    return 32'(1 << off);
      2'd1:    return (off >= 2) ? 32'hC : 32'h3;
      default: return 32'hF;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] w);
    case (sz)
      2'd0:    return (w & 32'hFF) * 32'h0101_0101;
      2'd1:    return (w & 32'hFFFF) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic uns,
                                           input logic [31:0] a, input logic [31:0] word);
    int off;
    logic [31:0] v;
    off = int'(a[1:0]);
    case (sz)
      2'd0: begin
        v = (word >> (8 * off)) & 32'hFF;
        if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end
      2'd1: begin
        v = (word >> (16 * (off / 2))) & 32'hFFFF;
        if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  // ---------------- driver ----------------
  // rv_dly < 0 means the bus never responds (timeout path).
  task automatic do_access(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                           input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
    logic al;
    logic exp_wb;
    int   nwait;
    al = is_aligned(sz, a);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd; req_rd = rd;
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    #1;
    chk("idle_stall", stall_o, al);
    chk("idle_misalign", misalign_o, !al);
    chk("idle_bus_req", bus_req, 1'b0);
    if (!al) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk("post_mis_misalign", misalign_o, 1'b0);
      chk("post_mis_bus_req", bus_req, 1'b0);
      chk("post_mis_stall", stall_o, 1'b0);
      return;
    end
    for (int k = 0; k <= gnt_dly; k++) begin
      @(negedge clk);
      bus_gnt = (k == gnt_dly);
      bus_rvalid = 1'($urandom_range(0, 1));
      bus_rdata = $urandom;
      #1;
      chk("req_bus_req", bus_req, 1'b1);
      chk("req_bus_we", bus_we, we);
      chk("req_bus_addr", bus_addr, a & 32'hFFFF_FFFC);
      chk("req_bus_be", bus_be, exp_be(sz, a));
      if (we) chk("req_bus_wdata", bus_wdata, exp_wdata(sz, wd));
      chk("req_stall", stall_o, 1'b1);
      chk("req_wb_we", wb_we, 1'b0);
    end
    nwait = (rv_dly < 0) ? 256 : rv_dly + 1;
    for (int k = 0; k < nwait; k++) begin
      @(negedge clk);
      bus_gnt = 1'b0;
      bus_rvalid = (rv_dly >= 0) && (k == rv_dly);
      bus_rdata = bus_rvalid ? rdata : $urandom;
      #1;
      chk("wait_bus_req", bus_req, 1'b0);
      chk("wait_stall", stall_o, 1'b1);
      chk("wait_wb_we", wb_we, 1'b0);
      chk("wait_bus_err", bus_err_o, (rv_dly < 0) && (k == 255));
    end
    @(negedge clk);
    bus_rvalid = 1'b0;
    req_valid = 1'b0;
    #1;
    exp_wb = !we && (rv_dly >= 0) && (rd != 5'd0);
    chk("done_stall", stall_o, 1'b0);
    chk("done_bus_req", bus_req, 1'b0);
    chk("done_bus_err", bus_err_o, 1'b0);
    chk("done_wb_we", wb_we, exp_wb);
    chk("done_wb_waddr", wb_waddr, exp_wb ? 32'(rd) : 32'd0);
    chk("done_wb_wdata", wb_wdata, exp_wb ? exp_load(sz, uns, a, rdata) : 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bus_req"}, bus_req, 1'b0);
    chk({tag, "_bus_we"}, bus_we, 1'b0);
    chk({tag, "_bus_addr"}, bus_addr, 32'd0);
    chk({tag, "_bus_be"}, bus_be, 4'd0);
    chk({tag, "_bus_wdata"}, bus_wdata, 32'd0);
    chk({tag, "_wb_we"}, wb_we, 1'b0);
    chk({tag, "_wb_waddr"}, wb_waddr, 5'd0);
    chk({tag, "_wb_wdata"}, wb_wdata, 32'd0);
    chk({tag, "_bus_err"}, bus_err_o, 1'b0);
    chk({tag, "_stall"}, stall_o, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // lb 0x1003 signed, minimum latency
    do_access(1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'd0, 5'd7, 0, 0, 32'h80FF_0000);
    // sh 0x2002, grant after two extra cycles
    do_access(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 5'd3, 2, 0, 32'd0);
    // lw misaligned
    do_access(1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'd0, 5'd5, 0, 0, 32'd0);
    // illegal size
    do_access(1'b0, 2'd3, 1'b0, 32'h0000_3000, 32'd0, 5'd5, 0, 0, 32'd0);
    // lw with no response: timeout
    do_access(1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'd0, 5'd9, 0, -1, 32'd0);
    // lbu to x0, then immediate lhu
    do_access(1'b0, 2'd0, 1'b1, 32'h0000_0020, 32'd0, 5'd0, 0, 0, 32'h0000_00F0);
    do_access(1'b0, 2'd1, 1'b1, 32'h0000_0010, 32'd0, 5'd4, 0, 0, 32'h0000_8001);

    // reset during WAIT, late response after release
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h0000_4000; req_rd = 5'd12;
    @(negedge clk); bus_gnt = 1'b1;
    @(negedge clk); bus_gnt = 1'b0;
    @(negedge clk);
    #1;
    chk("rstw_stall_before", stall_o, 1'b1);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    #1;
    chk_all_zero("rstw");
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
    #1;
    chk("rstw_late_wb_we", wb_we, 1'b0);
    chk("rstw_late_stall", stall_o, 1'b0);
    @(negedge clk); bus_rvalid = 1'b0;
    #1;
    chk_all_zero("rstw_after");

    // random accesses
    for (int n = 0; n < 60; n++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      do_access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 4), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 clk  in  1  core clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-003 req_valid  in  1  mem-stage load/store present; held stable while stall_o=1.
REQ-004 req_we  in  1  1 = store, 0 = load.
REQ-005 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-006 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-007 req_addr  in  32  byte address.
REQ-008 req_wdata  in  32  store data, right-aligned.
REQ-009 req_rd  in  5  load destination register.
REQ-010 stall_o  out  1  freeze upstream pipeline.
REQ-011 bus_req, bus_we  out  1,1  bus request / write strobe.
REQ-012 bus_addr  out  32  word-aligned address ({req_addr[31:2],2'b00}).
REQ-013 bus_be  out  4  byte enables; bus_wdata  out  32  lane-replicated store data.
REQ-014 bus_gnt, bus_rvalid  in  1,1  request accepted / response (load data or store ack).
REQ-015 bus_rdata  in  32  load response word.
REQ-016 wb_we, wb_waddr, wb_wdata  out  1,5,32  register writeback.
REQ-017 misalign_o, bus_err_o  out  1,1  one-cycle exception pulses.

Function
REQ-018 FSM states IDLE, REQ, WAIT, DONE; encoding free.
REQ-019 IDLE: req_valid=1 and aligned -> latch addr/be/wdata/we/size/unsigned/rd, go REQ; else stay.
- Aligned: byte always; half needs addr[0]=0; word needs addr[1:0]=00; size 11 never aligned.
REQ-020 IDLE with req_valid=1 and misaligned: misalign_o=1 (combinational), stall_o=0, no bus access, stay IDLE.
REQ-021 REQ: bus_req=1 with latched fields held constant; bus_gnt=1 -> WAIT.
REQ-022 WAIT: bus_req=0; bus_rvalid=1 -> capture data, go DONE; bus_rvalid ignored in every other state.
REQ-023 WAIT timeout: 8-bit counter cleared on WAIT entry, +1 per WAIT cycle; at 255 without rvalid -> bus_err_o pulse one cycle, go DONE with wb_we=0.
REQ-024 DONE: one cycle, stall_o=0, wb_* valid, unconditional -> IDLE.
REQ-025 stall_o = (IDLE & req_valid & aligned) | REQ | WAIT; 0 in DONE.
REQ-026 Minimum latency gnt-same-cycle, rvalid-next-cycle: IDLE->REQ->WAIT->DONE; 4 cycles, stall high 3.
REQ-027 bus_be:
- byte: 0001 << addr[1:0]
- half: addr[1] ? 1100 : 0011
- word: 1111
REQ-028 bus_wdata:
- byte: {4{wdata[7:0]}}
- half: {2{wdata[15:0]}}
- word: wdata
REQ-029 Load extract: byte lane addr[1:0], half lane addr[1]; extend per req_unsigned to 32 bits.
REQ-030 wb_we=1 in DONE only for a load, no timeout, rd!=0; wb_waddr=rd; wb_wdata=extracted value; all wb_* zero otherwise.
REQ-031 Stores: wait for rvalid ack exactly as loads; no writeback.
REQ-032 New request accepted in the IDLE cycle following DONE; back-to-back throughput one access per 4 cycles minimum.

Reset
REQ-033 rst=0 asynchronously forces IDLE, counter 0, and every registered output 0 (bus_req, bus_we, bus_addr, bus_be, bus_wdata, wb_*, bus_err_o).
REQ-034 Reset mid-REQ/WAIT abandons the access; a bus_rvalid arriving after reset release is ignored and produces no writeback.

Verification
REQ-035 lb addr 0x1003, rdata 0x80FF_0000, unsigned=0, gnt immediate, rvalid next cycle -> be=1000, addr 0x1000, DONE wb_wdata=0xFFFF_FF80 to rd, stall 3 cycles.
REQ-036 sh addr 0x2002 wdata 0x0000_ABCD, gnt after 2 wait cycles -> bus_req held 3 cycles, be=1100, bus_wdata=0xABCD_ABCD, wb_we never 1.
REQ-037 lw addr 0x3001 -> misalign_o=1 same cycle, stall_o=0, bus_req never asserted.
REQ-038 lw with no rvalid -> bus_err_o pulse after 255 WAIT cycles, wb_we=0, FSM IDLE next-next cycle.
REQ-039 rst low during WAIT, rvalid 2 cycles after release -> all outputs 0, no wb_we.
REQ-040 lbu rd=0, rdata 0x0000_00F0 -> wb_we=0; then immediate lhu 0x10 with rdata 0x0000_8001 -> wb_wdata=0x0000_8001.
